// File: rtl/tt_briscv_pkg.sv
// Shared load-queue types for the memory path.
// Optional feature macro: TT_LQ_FLUSH_EN (adds i_flush to tt_lq_tracker).
package tt_briscv_pkg;

  // Per-entry info carried from allocation to retire.
  typedef struct packed {
    logic       load;      // scalar load, waits for a completion
    logic       vec_load;  // vector load, waits for a completion
    logic [4:0] rd;        // destination register
    logic [2:0] size;      // access size code
  } lq_info_s;

  // lqid width for a given depth; never narrower than one bit.
  function automatic int lq_id_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int LQ_DEPTH_DEF  = 8;
  localparam int LQ_DATA_W_DEF = 256;
  localparam int LQ_ID_W_DEF   = lq_id_w(LQ_DEPTH_DEF);

  // One completion channel bundle, sized for the default tracker configuration.
  typedef struct packed {
    logic                     vld;
    logic [LQ_ID_W_DEF-1:0]   lqid;
    logic [LQ_DATA_W_DEF-1:0] data;
  } lq_cmpl_s;

endpackage

// File: rtl/tt_lq_ptr.sv
// Wrap-bit queue pointer: W-1 index bits plus one wrap bit.
// Optional feature macro: TT_LQ_FLUSH_EN (drives i_clr from the tracker).
module tt_lq_ptr #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: clear beats increment.
  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/tt_lq_tracker.sv
// Load-queue tracker: in-order alloc, out-of-order completion on WB_PORTS
// channels, in-order retire. Completion reaches retire one cycle later.
// Optional feature macro: TT_LQ_FLUSH_EN (adds i_flush, clears the queue).
module tt_lq_tracker
  import tt_briscv_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int DATA_W   = 256,
  parameter  int WB_PORTS = 2,
  localparam int ID_W     = lq_id_w(DEPTH)
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_alloc_vld,
  output logic                             o_alloc_rdy,
  input  lq_info_s                         i_alloc_info,
  output logic [ID_W-1:0]                  o_alloc_lqid,
  input  logic [WB_PORTS-1:0]              i_cmpl_vld,
  input  logic [WB_PORTS-1:0][ID_W-1:0]    i_cmpl_lqid,
  input  logic [WB_PORTS-1:0][DATA_W-1:0]  i_cmpl_data,
  output logic                             o_ret_vld,
  input  logic                             i_ret_rdy,
  output lq_info_s                         o_ret_info,
  output logic [DATA_W-1:0]                o_ret_data,
  output logic [ID_W:0]                    o_count,
  output logic                             o_empty,
  output logic                             o_full,
  output logic                             o_err
`ifdef TT_LQ_FLUSH_EN
  ,
  input  logic                             i_flush
`endif
);

  logic flush;
`ifdef TT_LQ_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  logic [ID_W:0]   head;
  logic [ID_W:0]   tail;
  logic [ID_W-1:0] head_idx;
  logic [ID_W-1:0] tail_idx;
  logic            alloc_fire;
  logic            ret_fire;
  logic            born_done;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] alloc_we;
  logic [DEPTH-1:0] ret_clr;
  logic [DEPTH-1:0] cmpl_hit;
  logic [DEPTH-1:0] cmpl_we;
  logic [DATA_W-1:0] hit_data [DEPTH];
  lq_info_s          info_q   [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];

  logic cmpl_err;
  logic err_q, err_d;

  assign head_idx = head[ID_W-1:0];
  assign tail_idx = tail[ID_W-1:0];

  assign o_empty = (head == tail);
  assign o_full  = (head[ID_W] != tail[ID_W]) && (head_idx == tail_idx);
  assign o_count = tail - head;

  assign o_alloc_rdy  = !o_full && !flush;
  assign o_alloc_lqid = tail_idx;
  assign alloc_fire   = i_alloc_vld && o_alloc_rdy;
  // Non-load entries need no return data, so they are ready to retire at once.
  assign born_done    = !(i_alloc_info.load || i_alloc_info.vec_load);

  assign o_ret_vld  = valid_q[head_idx] && done_q[head_idx] && !flush;
  assign ret_fire   = o_ret_vld && i_ret_rdy;
  assign o_ret_info = o_ret_vld ? info_q[head_idx] : '0;
  assign o_ret_data = o_ret_vld ? data_q[head_idx] : '0;

  tt_lq_ptr #(.W(ID_W + 1)) u_head_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (flush),
    .i_inc   (ret_fire),
    .o_ptr   (head)
  );

  tt_lq_ptr #(.W(ID_W + 1)) u_tail_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (flush),
    .i_inc   (alloc_fire),
    .o_ptr   (tail)
  );

  // Per-entry completion match; scanning ports downward lets the lowest port win.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      cmpl_hit[e] = 1'b0;
      hit_data[e] = '0;
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (i_cmpl_vld[p] && (i_cmpl_lqid[p] == ID_W'(e))) begin
          cmpl_hit[e] = 1'b1;
          hit_data[e] = i_cmpl_data[p];
        end
      end
    end
  end

  // Protocol errors: completion to a free or already-done entry, or two ports on one lqid.
  always_comb begin
    cmpl_err = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (i_cmpl_vld[p]) begin
        if (!valid_q[i_cmpl_lqid[p]] || done_q[i_cmpl_lqid[p]]) begin
          cmpl_err = 1'b1;
        end
        for (int q = 0; q < p; q++) begin
          if (i_cmpl_vld[q] && (i_cmpl_lqid[q] == i_cmpl_lqid[p])) begin
            cmpl_err = 1'b1;
          end
        end
      end
    end
  end

  // Per-entry valid/done next state; allocation and retire never target the same live entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign alloc_we[gi] = alloc_fire && (tail_idx == ID_W'(gi));
    assign ret_clr[gi]  = ret_fire && (head_idx == ID_W'(gi));
    assign cmpl_we[gi]  = cmpl_hit[gi] && valid_q[gi] && !done_q[gi] && !flush;

    assign valid_d[gi] = flush        ? 1'b0 :
                         alloc_we[gi] ? 1'b1 :
                         ret_clr[gi]  ? 1'b0 : valid_q[gi];
    assign done_d[gi]  = flush        ? 1'b0 :
                         alloc_we[gi] ? born_done :
                         ret_clr[gi]  ? 1'b0 :
                         cmpl_we[gi]  ? 1'b1 : done_q[gi];
  end

  // Entry status bits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Entry payload; contents are only observed while the entry is valid, so no reset.
  always_ff @(posedge i_clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (alloc_we[e]) begin
        info_q[e] <= i_alloc_info;
        data_q[e] <= '0;
      end else if (cmpl_we[e]) begin
        data_q[e] <= hit_data[e];
      end
    end
  end

  // Sticky error: completions during a flush are dropped silently.
  always_comb begin
    err_d = err_q;
    if (cmpl_err && !flush) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_tt_lq_tracker.sv
// Directed table-driven bench for tt_lq_tracker (DEPTH=8, DATA_W=256, WB_PORTS=2).
// Flush sequence is built only with TT_LQ_FLUSH_EN.
module tb_tt_lq_tracker;
  import tt_briscv_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 256;
  localparam int NP    = 2;
  localparam int IW    = 3;

  logic                     clk = 1'b0;
  logic                     i_reset;
  logic                     i_alloc_vld;
  logic                     o_alloc_rdy;
  lq_info_s                 i_alloc_info;
  logic [IW-1:0]            o_alloc_lqid;
  logic [NP-1:0]            i_cmpl_vld;
  logic [NP-1:0][IW-1:0]    i_cmpl_lqid;
  logic [NP-1:0][DW-1:0]    i_cmpl_data;
  logic                     o_ret_vld;
  logic                     i_ret_rdy;
  lq_info_s                 o_ret_info;
  logic [DW-1:0]            o_ret_data;
  logic [IW:0]              o_count;
  logic                     o_empty;
  logic                     o_full;
  logic                     o_err;
`ifdef TT_LQ_FLUSH_EN
  logic                     i_flush;
`endif

  always #5 clk = ~clk;

  tt_lq_tracker #(.DEPTH(DEPTH), .DATA_W(DW), .WB_PORTS(NP)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_alloc_vld  (i_alloc_vld),
    .o_alloc_rdy  (o_alloc_rdy),
    .i_alloc_info (i_alloc_info),
    .o_alloc_lqid (o_alloc_lqid),
    .i_cmpl_vld   (i_cmpl_vld),
    .i_cmpl_lqid  (i_cmpl_lqid),
    .i_cmpl_data  (i_cmpl_data),
    .o_ret_vld    (o_ret_vld),
    .i_ret_rdy    (i_ret_rdy),
    .o_ret_info   (o_ret_info),
    .o_ret_data   (o_ret_data),
    .o_count      (o_count),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_err        (o_err)
`ifdef TT_LQ_FLUSH_EN
    ,
    .i_flush      (i_flush)
`endif
  );

  typedef struct {
    logic          rst;
    logic          av;
    lq_info_s      ai;
    logic [1:0]    cv;
    logic [IW-1:0] cl0;
    logic [31:0]   cd0;
    logic [IW-1:0] cl1;
    logic [31:0]   cd1;
    logic          rr;
    logic          e_rdy;
    logic [IW-1:0] e_lqid;
    logic          e_rv;
    lq_info_s      e_info;
    logic [31:0]   e_data;
    logic [IW:0]   e_cnt;
    logic          e_empty;
    logic          e_full;
    logic          e_err;
  } vec_t;

  localparam int NROWS = 31;
  vec_t tbl [NROWS];

  int n_pass  = 0;
  int n_total = 0;

  function automatic lq_info_s mk(input logic l, input logic v, input logic [4:0] rd);
    lq_info_s x;
    x.load     = l;
    x.vec_load = v;
    x.rd       = rd;
    x.size     = 3'd2;
    return x;
  endfunction

  function automatic vec_t r(
    input logic rst, input logic av, input lq_info_s ai,
    input logic [1:0] cv, input logic [IW-1:0] cl0, input logic [31:0] cd0,
    input logic [IW-1:0] cl1, input logic [31:0] cd1, input logic rr,
    input logic e_rdy, input logic [IW-1:0] e_lqid, input logic e_rv,
    input lq_info_s e_info, input logic [31:0] e_data, input logic [IW:0] e_cnt,
    input logic e_empty, input logic e_full, input logic e_err);
    vec_t v;
    v.rst = rst; v.av = av; v.ai = ai; v.cv = cv;
    v.cl0 = cl0; v.cd0 = cd0; v.cl1 = cl1; v.cd1 = cd1; v.rr = rr;
    v.e_rdy = e_rdy; v.e_lqid = e_lqid; v.e_rv = e_rv; v.e_info = e_info;
    v.e_data = e_data; v.e_cnt = e_cnt; v.e_empty = e_empty;
    v.e_full = e_full; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got %0h expected %0h", nm, idx, act, exp);
  endtask

  task automatic idle_inputs();
    i_reset      = 1'b0;
    i_alloc_vld  = 1'b0;
    i_alloc_info = '0;
    i_cmpl_vld   = '0;
    i_cmpl_lqid  = '0;
    i_cmpl_data  = '0;
    i_ret_rdy    = 1'b0;
`ifdef TT_LQ_FLUSH_EN
    i_flush      = 1'b0;
`endif
  endtask

  // Drive one row at the falling edge, check state-driven outputs before the next rise.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    idle_inputs();
    i_reset        = v.rst;
    i_alloc_vld    = v.av;
    i_alloc_info   = v.ai;
    i_cmpl_vld     = v.cv;
    i_cmpl_lqid[0] = v.cl0;
    i_cmpl_lqid[1] = v.cl1;
    i_cmpl_data[0] = {8{v.cd0}};
    i_cmpl_data[1] = {8{v.cd1}};
    i_ret_rdy      = v.rr;
    #1;
    $display("row %0d: rdy=%0b lqid=%0d ret_vld=%0b count=%0d err=%0b",
             idx, o_alloc_rdy, o_alloc_lqid, o_ret_vld, o_count, o_err);
    chk("alloc_rdy", idx, DW'(o_alloc_rdy), DW'(v.e_rdy));
    chk("alloc_lqid", idx, DW'(o_alloc_lqid), DW'(v.e_lqid));
    chk("ret_vld", idx, DW'(o_ret_vld), DW'(v.e_rv));
    chk("ret_info", idx, DW'(o_ret_info), DW'(v.e_info));
    chk("ret_data", idx, o_ret_data, v.e_rv ? {8{v.e_data}} : '0);
    chk("count", idx, DW'(o_count), DW'(v.e_cnt));
    chk("empty", idx, DW'(o_empty), DW'(v.e_empty));
    chk("full", idx, DW'(o_full), DW'(v.e_full));
    chk("err", idx, DW'(o_err), DW'(v.e_err));
  endtask

  initial begin
    lq_info_s z;
    logic [31:0] a0, a1, a2, b0, b1, c9;
    z  = '0;
    a0 = 32'h1111_0000; a1 = 32'h2222_0001; a2 = 32'h3333_0002;
    b0 = 32'hB0B0_0003; b1 = 32'hB1B1_0003; c9 = 32'hC0DE_0009;

    //                 rst av info        cv  cl0 cd0 cl1 cd1 rr | rdy lqid rv info       data cnt emp full err
    tbl[0]  = r(0, 0, z,           0, 0, 0,  0, 0,  0,   1, 0, 0, z,          0,  0, 1, 0, 0);
    for (int k = 0; k < 8; k++)
      tbl[1+k] = r(0, 1, mk(1, 0, 5'(k)), 0, 0, 0, 0, 0, 0,
                   1, 3'(k), 0, z, 0, 4'(k), (k == 0), 0, 0);
    tbl[9]  = r(0, 1, mk(1, 0, 0), 0, 0, 0,  0, 0,  0,   0, 0, 0, z,          0,  8, 0, 1, 0);
    tbl[10] = r(0, 0, z,           3, 2, a2, 1, a1, 0,   0, 0, 0, z,          0,  8, 0, 1, 0);
    tbl[11] = r(0, 0, z,           1, 0, a0, 0, 0,  1,   0, 0, 0, z,          0,  8, 0, 1, 0);
    tbl[12] = r(0, 0, z,           0, 0, 0,  0, 0,  1,   0, 0, 1, mk(1,0,0),  a0, 8, 0, 1, 0);
    tbl[13] = r(0, 0, z,           0, 0, 0,  0, 0,  1,   1, 0, 1, mk(1,0,1),  a1, 7, 0, 0, 0);
    tbl[14] = r(0, 0, z,           0, 0, 0,  0, 0,  0,   1, 0, 1, mk(1,0,2),  a2, 6, 0, 0, 0);
    tbl[15] = r(0, 0, z,           0, 0, 0,  0, 0,  0,   1, 0, 1, mk(1,0,2),  a2, 6, 0, 0, 0);
    tbl[16] = r(0, 0, z,           0, 0, 0,  0, 0,  1,   1, 0, 1, mk(1,0,2),  a2, 6, 0, 0, 0);
    tbl[17] = r(0, 0, z,           3, 3, b0, 3, b1, 0,   1, 0, 0, z,          0,  5, 0, 0, 0);
    tbl[18] = r(0, 0, z,           0, 0, 0,  0, 0,  1,   1, 0, 1, mk(1,0,3),  b0, 5, 0, 0, 1);
    tbl[19] = r(1, 0, z,           0, 0, 0,  0, 0,  0,   1, 0, 0, z,          0,  4, 0, 0, 1);
    tbl[20] = r(0, 1, mk(0,0,5),   0, 0, 0,  0, 0,  0,   1, 0, 0, z,          0,  0, 1, 0, 0);
    tbl[21] = r(0, 0, z,           0, 0, 0,  0, 0,  0,   1, 1, 1, mk(0,0,5),  0,  1, 0, 0, 0);
    tbl[22] = r(0, 0, z,           2, 0, 0,  0, 32'hDEAD_BEEF, 1, 1, 1, 1, mk(0,0,5), 0, 1, 0, 0, 0);
    tbl[23] = r(1, 0, z,           0, 0, 0,  0, 0,  0,   1, 1, 0, z,          0,  0, 1, 0, 1);
    tbl[24] = r(0, 0, z,           1, 4, 32'h5555_5555, 0, 0, 0, 1, 0, 0, z,  0,  0, 1, 0, 0);
    tbl[25] = r(0, 0, z,           0, 0, 0,  0, 0,  0,   1, 0, 0, z,          0,  0, 1, 0, 1);
    tbl[26] = r(1, 0, z,           0, 0, 0,  0, 0,  0,   1, 0, 0, z,          0,  0, 1, 0, 1);
    tbl[27] = r(0, 1, mk(0,1,9),   0, 0, 0,  0, 0,  0,   1, 0, 0, z,          0,  0, 1, 0, 0);
    tbl[28] = r(0, 0, z,           2, 0, 0,  0, c9, 0,   1, 1, 0, z,          0,  1, 0, 0, 0);
    tbl[29] = r(0, 0, z,           0, 0, 0,  0, 0,  1,   1, 1, 1, mk(0,1,9),  c9, 1, 0, 0, 0);
    tbl[30] = r(0, 0, z,           0, 0, 0,  0, 0,  0,   1, 1, 0, z,          0,  0, 1, 0, 0);

    // Power-on reset.
    idle_inputs();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;

    for (int i = 0; i < NROWS; i++) apply(i, tbl[i]);

    // Fill with born-done entries, then retire+alloc every cycle across the wrap.
    @(negedge clk);
    idle_inputs();
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      i_alloc_vld  = 1'b1;
      i_alloc_info = mk(0, 0, 5'(k));
      @(negedge clk);
    end
    i_alloc_vld = 1'b1;
    i_ret_rdy   = 1'b1;
    #1;
    $display("wrap setup: count=%0d full=%0b rdy=%0b", o_count, o_full, o_alloc_rdy);
    chk("wrap_full", 100, DW'(o_full), DW'(1'b1));
    chk("wrap_full_rdy", 100, DW'(o_alloc_rdy), DW'(1'b0));
    chk("wrap_full_rv", 100, DW'(o_ret_vld), DW'(1'b1));
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      i_alloc_info = mk(0, 0, 5'(i));
      #1;
      $display("wrap %0d: lqid=%0d count=%0d ret_vld=%0b", i, o_alloc_lqid, o_count, o_ret_vld);
      chk("wrap_count", 200 + i, DW'(o_count), DW'(7));
      chk("wrap_rdy", 200 + i, DW'(o_alloc_rdy), DW'(1'b1));
      chk("wrap_lqid", 200 + i, DW'(o_alloc_lqid), DW'(i % 8));
      chk("wrap_rv", 200 + i, DW'(o_ret_vld), DW'(1'b1));
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("wrap_end_count", 300, DW'(o_count), DW'(7));
    chk("wrap_end_err", 300, DW'(o_err), DW'(1'b0));

`ifdef TT_LQ_FLUSH_EN
    // Five loads in flight, then flush with an alloc and a stray completion.
    @(negedge clk);
    idle_inputs();
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_alloc_vld  = 1'b1;
      i_alloc_info = mk(1, 0, 5'(k));
      @(negedge clk);
    end
    i_alloc_vld    = 1'b1;
    i_flush        = 1'b1;
    i_cmpl_vld     = 2'b01;
    i_cmpl_lqid[0] = 3'd6;
    #1;
    $display("flush: count=%0d rdy=%0b ret_vld=%0b", o_count, o_alloc_rdy, o_ret_vld);
    chk("flush_count_before", 400, DW'(o_count), DW'(5));
    chk("flush_rdy", 400, DW'(o_alloc_rdy), DW'(1'b0));
    chk("flush_rv", 400, DW'(o_ret_vld), DW'(1'b0));
    @(negedge clk);
    idle_inputs();
    #1;
    $display("post flush: count=%0d empty=%0b err=%0b", o_count, o_empty, o_err);
    chk("flush_count", 401, DW'(o_count), DW'(0));
    chk("flush_empty", 401, DW'(o_empty), DW'(1'b1));
    chk("flush_err", 401, DW'(o_err), DW'(1'b0));
    chk("flush_lqid", 401, DW'(o_alloc_lqid), DW'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
